// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict/resolve unit: funct3 encodings,
// 2-bit saturating counter type and its update function.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    // Move one step toward the resolved direction, saturating at the ends.
    function automatic ctr_t ctr_update(input ctr_t cur, input logic taken);
        ctr_t nxt;
        case (cur)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_cmp.sv
// branch_cmp: combinational branch condition evaluation from raw operands.
// Reserved funct3 codes 010/011 report illegal and never taken.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [2:0]      funct3,
    output logic            taken,
    output logic            illegal
);

    logic eq;
    logic lt;
    logic ltu;

    assign eq  = (rs1 == rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));
    assign ltu = (rs1 < rs2);

    // Select the branch condition for the given funct3.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = eq;
            F3_BNE:  taken = ~eq;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: begin
                taken   = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: registered BHT lookups and one-cycle branch resolution.
// The 2-bit counter table exists only when BRANCH_BHT_EN is defined.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int INDEX_LSB   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pred_req,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic [XLEN-1:0] res_pc,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic            res_pred,
    output logic            out_valid,
    output logic            out_taken,
    output logic            out_mispredict,
    output logic            out_illegal
);

    localparam int IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

    logic cmp_taken;
    logic cmp_illegal;
    logic lookup_taken;
    logic mispredict;
    logic unused_bits;

    // Only the index field of each PC matters; the rest is folded away here.
    assign unused_bits = ^{pred_pc, res_pc, res_pred};

    branch_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .rs1    (res_rs1),
        .rs2    (res_rs2),
        .funct3 (res_funct3),
        .taken  (cmp_taken),
        .illegal(cmp_illegal)
    );

`ifdef BRANCH_BHT_EN
    ctr_t             bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;

    assign pred_idx = pred_pc[INDEX_LSB +: IDX_W];
    assign res_idx  = res_pc[INDEX_LSB +: IDX_W];

    // Lookup reads the pre-update counter; same-cycle resolves are not bypassed.
    assign lookup_taken = bht[pred_idx][1];
    assign mispredict   = ~cmp_illegal & (cmp_taken ^ res_pred);

    // Counter table: flops so that reset can return every entry to weak-NT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= WNT;
            end
        end else if (res_valid && !cmp_illegal) begin
            bht[res_idx] <= ctr_update(bht[res_idx], cmp_taken);
        end
    end
`else
    // Static not-taken: every taken branch is a mispredict.
    assign lookup_taken = 1'b0;
    assign mispredict   = cmp_taken;
`endif

    // Registered prediction and resolution outputs; resolution fields are 0 when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid     <= 1'b0;
            pred_taken     <= 1'b0;
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            pred_valid <= pred_req;
            if (pred_req) begin
                pred_taken <= lookup_taken;
            end
            out_valid      <= res_valid;
            out_taken      <= res_valid & cmp_taken;
            out_mispredict <= res_valid & mispredict;
            out_illegal    <= res_valid & cmp_illegal;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: table-driven resolve vectors,
// hand sequences for counter saturation, aliasing, same-cycle hazards and reset.
module tb_branch_predict_unit;

    localparam int N = 64;

    logic        clk;
    logic        rst;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;
    logic        res_valid;
    logic [31:0] res_pc;
    logic [2:0]  res_funct3;
    logic [31:0] res_rs1;
    logic [31:0] res_rs2;
    logic        res_pred;
    logic        out_valid;
    logic        out_taken;
    logic        out_mispredict;
    logic        out_illegal;

    branch_predict_unit #(
        .XLEN(32), .BHT_ENTRIES(N), .INDEX_LSB(2)
    ) dut (
        .clk(clk), .rst(rst),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
        .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pred(res_pred),
        .out_valid(out_valid), .out_taken(out_taken),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic pv, pt, ov, ot, om, oi;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        rp;
        logic        et;
        logic        ei;
    } vec_t;

    exp_t       sb[$];
    vec_t       vecs[12];
    logic [1:0] mdl[N];
    logic       held_pt;
    int         errors = 0;
    int         checks = 0;

    function automatic logic bht_on();
`ifdef BRANCH_BHT_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mdl[i] = 2'b01;
        held_pt = 1'b0;
    endtask

    // One cycle of stimulus with predicted results pushed to the scoreboard.
    task automatic cyc(input string tag,
                       input logic preq, input logic [31:0] ppc,
                       input logic rv, input logic [31:0] rpc, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b, input logic rp,
                       input logic et, input logic ei);
        exp_t e;
        int   k;
        pred_req = preq; pred_pc = ppc;
        res_valid = rv; res_pc = rpc; res_funct3 = f3;
        res_rs1 = a; res_rs2 = b; res_pred = rp;
        e.pv = preq;
        if (preq) held_pt = bht_on() ? mdl[idx_of(ppc)][1] : 1'b0;
        e.pt = held_pt;
        e.ov = rv;
        e.ot = rv & et & ~ei;
        e.oi = rv & ei;
        e.om = bht_on() ? (rv & ~ei & (et != rp)) : (rv & et & ~ei);
        sb.push_back(e);
        if (rv && !ei) begin
            k = idx_of(rpc);
            if (et && mdl[k] != 2'b11) mdl[k] = mdl[k] + 2'b01;
            else if (!et && mdl[k] != 2'b00) mdl[k] = mdl[k] - 2'b01;
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " pred_valid"}, pred_valid, e.pv);
        check({tag, " pred_taken"}, pred_taken, e.pt);
        check({tag, " out_valid"}, out_valid, e.ov);
        check({tag, " out_taken"}, out_taken, e.ot);
        check({tag, " out_mispredict"}, out_mispredict, e.om);
        check({tag, " out_illegal"}, out_illegal, e.oi);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc);
        cyc(tag, 1'b1, pc, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic rp,
                           input logic et, input logic ei);
        cyc(tag, 1'b0, 32'h0, 1'b1, pc, f3, a, b, rp, et, ei);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pred_valid"}, pred_valid, 1'b0);
        check({tag, " pred_taken"}, pred_taken, 1'b0);
        check({tag, " out_valid"}, out_valid, 1'b0);
        check({tag, " out_taken"}, out_taken, 1'b0);
        check({tag, " out_mispredict"}, out_mispredict, 1'b0);
        check({tag, " out_illegal"}, out_illegal, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{3'b100, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'b110, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b101, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b111, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 1'b0};
        vecs[4]  = '{3'b000, 32'h7,         32'h8,         1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 32'h7,         32'h8,         1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3'b100, 32'h3,         32'h3,         1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 32'h3,         32'h3,         1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b010, 32'h5,         32'h5,         1'b1, 1'b0, 1'b1};
        vecs[9]  = '{3'b011, 32'h0,         32'h1,         1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b110, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};

        rst = 1'b1;
        pred_req = 1'b0; pred_pc = 32'h0;
        res_valid = 1'b0; res_pc = 32'h0; res_funct3 = 3'b000;
        res_rs1 = 32'h0; res_rs2 = 32'h0; res_pred = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        lookup("lk100", 32'h100);
        resolve("beq100", 32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b0);
        lookup("lk100b", 32'h100);
        resolve("bne100", 32'h100, 3'b001, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            resolve($sformatf("vec%0d", i), 32'h804 + 32'(4 * i), vecs[i].f3,
                    vecs[i].a, vecs[i].b, vecs[i].rp, vecs[i].et, vecs[i].ei);
        end
        for (int i = 7; i < 10; i++) begin
            lookup($sformatf("lkvec%0d", i), 32'h804 + 32'(4 * i));
        end

        for (int i = 0; i < 4; i++) begin
            resolve($sformatf("sat%0d", i), 32'h40, 3'b000, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        end
        resolve("sat_nt", 32'h40, 3'b001, 32'd1, 32'd1, 1'b1, 1'b0, 1'b0);
        lookup("lk40", 32'h40);
        lookup("lk40alias", 32'h40 + 32'(4 * N));

        cyc("same200", 1'b1, 32'h200, 1'b1, 32'h200, 3'b000, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
        lookup("lk200", 32'h200);
        resolve("ill200", 32'h200, 3'b010, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        resolve("ill200b", 32'h200, 3'b011, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        lookup("lk200b", 32'h200);

        pred_req = 1'b1; pred_pc = 32'h40;
        res_valid = 1'b1; res_pc = 32'h40; res_funct3 = 3'b000;
        res_rs1 = 32'd3; res_rs2 = 32'd3; res_pred = 1'b0;
        @(posedge clk);
        #1;
        pred_req = 1'b0; res_valid = 1'b0;
        check("pre_rst out_valid", out_valid, 1'b1);
        check("pre_rst out_taken", out_taken, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lookup("post_rst40", 32'h40);
        lookup("post_rst100", 32'h100);
        lookup("post_rst82c", 32'h82c);
        resolve("post_rst_beq", 32'h100, 3'b000, 32'd4, 32'd4, 1'b1, 1'b1, 1'b0);
        cyc("idle", 1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the single-cycle branch decision logic. It computes branch outcomes from raw operands, so it no longer consumes precomputed eq/lt flags. It also keeps a direct-mapped branch history table (BHT) of 2-bit saturating counters that supplies registered taken/not-taken predictions to fetch. Resolution results and mispredict flags are returned one cycle later to the pipeline's redirect logic.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, counter table depth; power of two, 2..1024
- INDEX_LSB, 2, lowest PC bit used for the table index

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- pred_req  in  1  prediction lookup request
- pred_pc  in  XLEN  PC being fetched
- pred_valid  out  1  lookup result valid; registered
- pred_taken  out  1  predicted direction; registered
- res_valid  in  1  resolve request from execute
- res_pc  in  XLEN  PC of the branch being resolved
- res_funct3  in  3  branch funct3
- res_rs1, res_rs2  in  XLEN  operands
- res_pred  in  1  direction that was predicted for this branch
- out_valid  out  1  resolution result valid; registered
- out_taken  out  1  actual direction; registered
- out_mispredict  out  1  out_taken != res_pred; registered
- out_illegal  out  1  funct3 was 010 or 011; registered

## Operation
- Index: idx = pc[INDEX_LSB +: log2(BHT_ENTRIES)]. Upper PC bits are ignored, so aliasing is permitted.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter[1].
- Comparison, all at XLEN width:
  - eq = rs1 == rs2
  - lt = signed(rs1) < signed(rs2)
  - ltu = rs1 < rs2 unsigned
- Outcome by funct3:
  - 000 taken=eq
  - 001 taken=!eq
  - 100 taken=lt
  - 101 taken=!lt
  - 110 taken=ltu
  - 111 taken=!ltu
  - 010/011: taken=0, mispredict=0, illegal=1, no counter update
- Update on a legal resolve:
  - If taken, the counter increments and saturates at 11.
  - If not taken, the counter decrements and saturates at 00.
- Reset: every counter is 01. All outputs are 0.

## Timing
- Lookup latency is 1 cycle. pred_req at edge N gives pred_valid=1 and pred_taken for the cycle after edge N.
- With pred_req=0, pred_valid=0 and pred_taken holds its last value.
- Resolve latency is 1 cycle. out_* are valid for exactly one cycle after the accepting edge.
- All out_* are 0 when out_valid=0.
- The counter write occurs on the same edge that accepts res_valid.
- Same-cycle lookup and resolve to the same index: the lookup returns the pre-update counter (no bypass). A lookup in the following cycle sees the new value.
- No backpressure: one lookup and one resolve per cycle, both always accepted.
- Reset asserted mid-operation clears all counters to 01 and all outputs to 0 asynchronously. The first request after deassertion behaves as after power-up.

## Configuration
- BRANCH_BHT_EN defined: the counter table is present and the behaviour is as above.
- BRANCH_BHT_EN undefined: there is no table storage.
  - pred_taken is always 0 (static not-taken); pred_valid still follows pred_req with 1-cycle latency.
  - out_mispredict = out_taken.

## Structure
- Package branch_pkg holds:
  - funct3 localparams F3_BEQ/BNE/BLT/BGE/BLTU/BGEU
  - 2-bit counter typedef and constants SNT/WNT/WT/ST
  - a saturating-update function
- Sub-module branch_cmp (combinational): inputs rs1, rs2, funct3; outputs taken, illegal. It is reused by any later multi-issue variant.
- The table is a flop array, not an inferred RAM, because of the asynchronous reset.

## Test plan
- Reset then lookup pc=0x100 -> pred_valid=1, pred_taken=0 (counter 01).
- Resolve pc=0x100, BEQ, rs1=rs2=5, res_pred=0 -> out_taken=1, out_mispredict=1. A following lookup at 0x100 -> pred_taken=1 (counter 10).
- Operand sweep with rs1=0xFFFFFFFF, rs2=1:
  - BLT -> taken=1
  - BLTU -> taken=0
  - BGE -> taken=0
  - BGEU -> taken=1
- Four taken resolves then one not-taken at pc=0x40 -> counter saturates at 11 and drops to 10; prediction stays 1. Aliased pc=0x40+4*BHT_ENTRIES reads the same counter.
- Same-cycle lookup and resolve (taken) at 0x200 from 01 -> pred_taken=0 that cycle, 1 on the next lookup. funct3=010 -> out_illegal=1, counter unchanged.
- Assert rst between the resolve edge and the output cycle -> out_valid=0 immediately; all counters read 01 afterwards.
